// File: rtl/sobel_pkg.sv
// sobel_pkg: shared definitions for the Sobel gradient-to-pixel path.
//   shift_op_e   operation select for the shared shift unit
//   GRAD/PIX     default gradient and pixel widths
package sobel_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10
  } shift_op_e;

  localparam int GRAD_WIDTH_D = 11;  // 8-bit pixels -> +/-1020 fits
  localparam int PIX_WIDTH_D  = 8;

endpackage

// File: rtl/grad_normalize_shift.sv
// grad_normalize_shift: combinational shift unit (SLL / SRL / SRA).
//   a      operand
//   shamt  shift amount; amounts >= WIDTH_P give 0 (or sign fill for SRA)
//   op     shift operation
//   y      result
module grad_normalize_shift
  import sobel_pkg::*;
#(
  parameter int WIDTH_P       = 12,
  parameter int SHAMT_WIDTH_P = $clog2(WIDTH_P)
) (
  input  logic [WIDTH_P-1:0]       a,
  input  logic [SHAMT_WIDTH_P-1:0] shamt,
  input  shift_op_e                op,
  output logic [WIDTH_P-1:0]       y
);

  always_comb begin
    y = '0;
    unique case (op)
      SHIFT_SLL: y = a << shamt;
      SHIFT_SRL: y = a >> shamt;
      SHIFT_SRA: y = $unsigned($signed(a) >>> shamt);
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/grad_normalize.sv
// grad_normalize: Sobel gradient-to-pixel stage.
//   Stage 1 forms |gx|+|gy| and captures the per-beat controls.
//   Stage 2 scales by a logical right shift, saturates to pixel width and
//   optionally binarises against a threshold.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   valid_i/ready_o               input handshake
//   gx_i, gy_i                    signed gradients
//   shamt_i, thresh_en_i, thresh_i  per-beat controls
//   valid_o/ready_i               output handshake
//   pixel_o, sat_o                edge pixel, clip flag (before thresholding)
module grad_normalize
  import sobel_pkg::*;
#(
  parameter int  GRAD_WIDTH_P  = GRAD_WIDTH_D,
  parameter int  PIX_WIDTH_P   = PIX_WIDTH_D,
  localparam int SUM_WIDTH_P   = GRAD_WIDTH_P + 1,
  localparam int SHAMT_WIDTH_P = $clog2(SUM_WIDTH_P)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [GRAD_WIDTH_P-1:0]  gx_i,
  input  logic [GRAD_WIDTH_P-1:0]  gy_i,
  input  logic [SHAMT_WIDTH_P-1:0] shamt_i,
  input  logic                     thresh_en_i,
  input  logic [PIX_WIDTH_P-1:0]   thresh_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [PIX_WIDTH_P-1:0]   pixel_o,
  output logic                     sat_o
);

  // vld_pipe[1] = stage 1 full, vld_pipe[2] = stage 2 full (drives valid_o)
  logic [2:1] vld_pipe;
  logic       adv1, adv2, take;

  assign adv2    = ~vld_pipe[2] | ready_i;
  assign adv1    = adv2;
  assign ready_o = ~vld_pipe[1] | adv1;
  assign take    = valid_i & ready_o;
  assign valid_o = vld_pipe[2];

  // ---------------- stage 1: abs + add ----------------
  // Sign-extend by one bit first so that the most negative gradient
  // negates exactly.
  logic [SUM_WIDTH_P-1:0] gx_ext, gy_ext, abs_x, abs_y;

  assign gx_ext = {gx_i[GRAD_WIDTH_P-1], gx_i};
  assign gy_ext = {gy_i[GRAD_WIDTH_P-1], gy_i};
  assign abs_x  = gx_ext[SUM_WIDTH_P-1] ? -gx_ext : gx_ext;
  assign abs_y  = gy_ext[SUM_WIDTH_P-1] ? -gy_ext : gy_ext;

  logic [SUM_WIDTH_P-1:0]   sum1;
  logic [SHAMT_WIDTH_P-1:0] shamt1;
  logic                     ten1;
  logic [PIX_WIDTH_P-1:0]   th1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe[1] <= 1'b0;
      sum1        <= '0;
      shamt1      <= '0;
      ten1        <= 1'b0;
      th1         <= '0;
    end else begin
      if (take) begin
        vld_pipe[1] <= 1'b1;
        sum1        <= abs_x + abs_y;  // both <= 2^(GRAD_WIDTH_P-1): cannot overflow
        shamt1      <= shamt_i;
        ten1        <= thresh_en_i;
        th1         <= thresh_i;
      end else if (adv1) begin
        vld_pipe[1] <= 1'b0;
      end
    end
  end

  // ---------------- stage 2: scale, saturate, threshold ----------------
  logic [SUM_WIDTH_P-1:0] sh;
  logic                   sat2;
  logic [PIX_WIDTH_P-1:0] pix_sat, pix_fin;

  grad_normalize_shift #(
    .WIDTH_P       (SUM_WIDTH_P),
    .SHAMT_WIDTH_P (SHAMT_WIDTH_P)
  ) u_shift (
    .a     (sum1),
    .shamt (shamt1),
    .op    (SHIFT_SRL),
    .y     (sh)
  );

  assign sat2    = |sh[SUM_WIDTH_P-1:PIX_WIDTH_P];
  assign pix_sat = sat2 ? '1 : sh[PIX_WIDTH_P-1:0];
  assign pix_fin = ten1 ? ((pix_sat >= th1) ? '1 : '0) : pix_sat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe[2] <= 1'b0;
      pixel_o     <= '0;
      sat_o       <= 1'b0;
    end else if (adv2) begin
      vld_pipe[2] <= vld_pipe[1];
      // data only moves with a real beat so idle cycles leave outputs quiet
      if (vld_pipe[1]) begin
        pixel_o <= pix_fin;
        sat_o   <= sat2;
      end
    end
  end

endmodule
